// File: rtl/fgp_gen_if.sv
// fgp_gen_if: byte-stream and frame-RAM signals of the FGP transmit block.
//   start, offset : packet request and its offset byte
//   ram_addr      : color read address {offset, color_idx}
//   ram_out       : color data, valid one cycle after ram_addr
//   rdy           : downstream accepts a byte this cycle
//   outclk, out   : byte strobe and byte value
//   busy, done    : packet in progress / last data byte strobe
// master: the generator; slave: its environment (RAM, requester, sink).
interface fgp_gen_if;
  logic        start;
  logic [7:0]  offset;
  logic [16:0] ram_addr;
  logic [11:0] ram_out;
  logic        rdy;
  logic        outclk;
  logic [7:0]  out;
  logic        busy;
  logic        done;

  modport master (
    input  start, offset, ram_out, rdy,
    output ram_addr, outclk, out, busy, done
  );

  modport slave (
    output start, offset, ram_out, rdy,
    input  ram_addr, outclk, out, busy, done
  );
endinterface

// File: rtl/fgp_gen.sv
// fgp_gen: FGP packet transmitter. Per accepted start it emits 1 offset byte,
// 127 padding bytes and 768 data bytes (512 12-bit colors, two per 3 bytes).
// Ports: clk, rst (sync, active high), bus (fgp_gen_if.master).
// outclk, out and done are combinational so a byte moves in the cycle rdy is
// seen; ram_addr and busy are registered.
// Build option: define FGP_GEN_LFSR_PAD_EN for LFSR padding instead of 0x00.
module fgp_gen (
  input  logic      clk,
  input  logic      rst,
  fgp_gen_if.master bus
);
  localparam int unsigned FGP_OFFSET_LEN      = 1;
  localparam int unsigned FGP_PADDING_LEN     = 127;
  localparam int unsigned FGP_DATA_LEN        = 768;
  localparam int unsigned FGP_DATA_LEN_COLORS = 512;
  localparam int unsigned COLOR_LEN           = 12;
  localparam int unsigned CNT_W               = 10;
  localparam int unsigned IDX_W               = 9;
  localparam int unsigned BUF_DEPTH           = 8;
  localparam int unsigned PTR_W               = 3;
  localparam int unsigned BCNT_W              = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, OFFSET, PADDING, DATA} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     byte_cnt;
  logic [1:0]           phase;
  logic [7:0]           offset_q;
  logic [CNT_W-1:0]     fetch_idx;
  logic                 rd_pend;
  logic                 rd_valid;
  logic [COLOR_LEN-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [BCNT_W-1:0]    buf_cnt;

  logic                 start_acc_c, byte_avail_c, xfer_c, last_c, pop_c, issue_c;
  logic [BCNT_W-1:0]    occ_c;
  logic [COLOR_LEN-1:0] c0_c, c1_c;
  logic [7:0]           pad_byte_c, out_c;

  assign start_acc_c  = (state == IDLE) && bus.start;
  assign byte_avail_c = (state != DATA) || (buf_cnt >= BCNT_W'(2));
  assign xfer_c       = bus.rdy && (state != IDLE) && byte_avail_c;
  assign pop_c        = xfer_c && (state == DATA) && (phase == 2'd2);
  assign c0_c         = buf_mem[rd_ptr];
  assign c1_c         = buf_mem[rd_ptr + PTR_W'(1)];

  // Buffer slots already committed, including reads still in flight.
  assign occ_c   = buf_cnt + BCNT_W'(rd_pend) + BCNT_W'(rd_valid);
  assign issue_c = ((state == PADDING) || (state == DATA)) &&
                   (fetch_idx < CNT_W'(FGP_DATA_LEN_COLORS)) &&
                   (occ_c < BCNT_W'(BUF_DEPTH));

  // Last byte index of the current section.
  always_comb begin
    last_c = 1'b0;
    case (state)
      OFFSET:  last_c = (byte_cnt == CNT_W'(FGP_OFFSET_LEN - 1));
      PADDING: last_c = (byte_cnt == CNT_W'(FGP_PADDING_LEN - 1));
      DATA:    last_c = (byte_cnt == CNT_W'(FGP_DATA_LEN - 1));
      default: last_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)       state_nxt = OFFSET;
      OFFSET:  if (xfer_c && last_c) state_nxt = PADDING;
      PADDING: if (xfer_c && last_c) state_nxt = DATA;
      DATA:    if (xfer_c && last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte counters, color fetch and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q     <= '0;
      byte_cnt     <= '0;
      phase        <= '0;
      fetch_idx    <= '0;
      rd_pend      <= 1'b0;
      rd_valid     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      buf_cnt      <= '0;
      bus.ram_addr <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.busy <= (state_nxt != IDLE);
      if (start_acc_c) begin
        offset_q  <= bus.offset;
        byte_cnt  <= '0;
        phase     <= '0;
        fetch_idx <= '0;
        rd_pend   <= 1'b0;
        rd_valid  <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        buf_cnt   <= '0;
      end else begin
        if (xfer_c) begin
          byte_cnt <= last_c ? '0 : byte_cnt + CNT_W'(1);
          if (state == DATA) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
        // Read data is captured on the cycle it is valid, regardless of rdy.
        rd_pend  <= issue_c;
        rd_valid <= rd_pend;
        if (issue_c) begin
          bus.ram_addr <= {offset_q, fetch_idx[IDX_W-1:0]};
          fetch_idx    <= fetch_idx + CNT_W'(1);
        end
        if (rd_valid) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)    rd_ptr <= rd_ptr + PTR_W'(2);
        buf_cnt <= buf_cnt + BCNT_W'(rd_valid) - (pop_c ? BCNT_W'(2) : BCNT_W'(0));
      end
    end
  end

  // Color buffer storage.
  always_ff @(posedge clk) begin
    if (rd_valid) buf_mem[wr_ptr] <= bus.ram_out;
  end

`ifdef FGP_GEN_LFSR_PAD_EN
  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, one step per padding byte.
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst || start_acc_c)
      lfsr <= 8'h01;
    else if (xfer_c && (state == PADDING))
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign pad_byte_c = lfsr;
`else
  assign pad_byte_c = 8'h00;
`endif

  // Output byte select; data pairs pack as c0[11:4], {c0[3:0],c1[11:8]}, c1[7:0].
  always_comb begin
    out_c = 8'h00;
    case (state)
      OFFSET:  out_c = offset_q;
      PADDING: out_c = pad_byte_c;
      DATA: begin
        case (phase)
          2'd0:    out_c = c0_c[11:4];
          2'd1:    out_c = {c0_c[3:0], c1_c[11:8]};
          default: out_c = c1_c[7:0];
        endcase
      end
      default: out_c = 8'h00;
    endcase
  end

  assign bus.outclk = xfer_c;
  assign bus.out    = out_c;
  assign bus.done   = xfer_c && (state == DATA) && last_c;
endmodule

// File: tb/tb_fgp_gen.sv
// tb_fgp_gen: scoreboard bench for fgp_gen. Expected bytes and RAM addresses
// are queued when a start is driven and popped as the DUT produces them.
// The RAM model returns color = index. Define FGP_GEN_LFSR_PAD_EN to match an
// LFSR-padding build.
module tb_fgp_gen;
  logic clk = 1'b0;
  logic rst;
  fgp_gen_if bus ();

  fgp_gen dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Frame RAM: one-cycle read latency, color = index.
  always @(posedge clk) bus.ram_out <= {3'b000, bus.ram_addr[8:0]};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [8:0]  sb_q[$];    // {done, byte}
  logic [16:0] addr_q[$];
  logic [16:0] prev_addr = '0;
  logic [8:0]  sb_e;
  logic        flush    = 1'b1;
  logic        rdy_rand = 1'b0;
  int          xfer_cnt = 0;

  // Queue the expected byte stream and read addresses of one packet.
  task automatic push_packet(input logic [7:0] off);
    logic [11:0] c0, c1;
`ifdef FGP_GEN_LFSR_PAD_EN
    logic [7:0] pad;
    pad = 8'h01;
`endif
    sb_q.push_back({1'b0, off});
    for (int i = 0; i < 127; i++) begin
`ifdef FGP_GEN_LFSR_PAD_EN
      sb_q.push_back({1'b0, pad});
      pad = {pad[6:0], pad[7] ^ pad[5] ^ pad[4] ^ pad[3]};
`else
      sb_q.push_back(9'h000);
`endif
    end
    for (int p = 0; p < 256; p++) begin
      c0 = 12'(2 * p);
      c1 = 12'(2 * p + 1);
      sb_q.push_back({1'b0, c0[11:4]});
      sb_q.push_back({1'b0, c0[3:0], c1[11:8]});
      sb_q.push_back({p == 255, c1[7:0]});
    end
    for (int i = 0; i < 512; i++) addr_q.push_back({off, 9'(i)});
  endtask

  // Output monitor: byte stream, done placement, rdy compliance, read order.
  always @(negedge clk) begin
    if (flush) begin
      prev_addr = bus.ram_addr;
    end else begin
      if (bus.outclk) begin
        check("outclk_without_rdy", 32'(bus.rdy), 1);
        if (sb_q.size() == 0) begin
          check("extra_byte", 32'(sb_q.size()), 1);
        end else begin
          sb_e = sb_q.pop_front();
          check("byte", 32'(bus.out), 32'(sb_e[7:0]));
          check("done", 32'(bus.done), 32'(sb_e[8]));
        end
        xfer_cnt++;
      end else begin
        check("done_without_outclk", 32'(bus.done), 0);
      end
      if (bus.ram_addr != prev_addr) begin
        if (addr_q.size() == 0) check("extra_read", 32'(addr_q.size()), 1);
        else                    check("ram_addr", 32'(bus.ram_addr), 32'(addr_q.pop_front()));
        prev_addr = bus.ram_addr;
      end
    end
  end

  // Random rdy driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) bus.rdy = 1'($urandom_range(1, 0));
    end
  end

  task automatic send_start(input logic [7:0] off);
    @(posedge clk); #1;
    push_packet(off);
    xfer_cnt   = 0;
    bus.offset = off;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Counts cycles and transfers from the first cycle after start acceptance
  // up to and including the done cycle.
  task automatic run_packet(input int max_cyc, output int n_cyc, output int n_xfer);
    logic seen;
    seen   = 1'b0;
    n_cyc  = 0;
    n_xfer = 0;
    while (!seen && n_cyc < max_cyc) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 1) check("busy_first", 32'(bus.busy), 1);
      if (bus.outclk) n_xfer++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic wait_xfer(input int n, input int max_cyc);
    int g;
    g = 0;
    while (xfer_cnt < n && g < max_cyc) begin
      @(negedge clk); #2;
      g++;
    end
    if (xfer_cnt < n) check("xfer_timeout", 32'(xfer_cnt), 32'(n));
  endtask

  // The cycle after done: idle, not busy, every expected byte and read seen.
  task automatic post_packet();
    @(negedge clk);
    check("busy_after", 32'(bus.busy), 0);
    check("outclk_after", 32'(bus.outclk), 0);
    check("bytes_left", 32'(sb_q.size()), 0);
    check("reads_left", 32'(addr_q.size()), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_outclk", 32'(bus.outclk), 0);
    check("rst_out", 32'(bus.out), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
  endtask

  int nc, nx;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.offset = 8'h00;
    bus.rdy    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst   = 1'b0;
    flush = 1'b0;

    // Basic packet, rdy held high: 896 back-to-back bytes.
    bus.rdy = 1'b1;
    send_start(8'h05);
    run_packet(2000, nc, nx);
    check("pkt1_cycles", 32'(nc), 896);
    check("pkt1_xfers", 32'(nx), 896);
    check("busy_on_done", 32'(bus.busy), 1);
    post_packet();

    // Random rdy.
    rdy_rand = 1'b1;
    send_start(8'h5A);
    run_packet(20000, nc, nx);
    check("rand_xfers", 32'(nx), 896);
    rdy_rand = 1'b0;
    bus.rdy  = 1'b1;
    post_packet();

    // rdy low on the last byte holds done back until it transfers.
    send_start(8'hC3);
    wait_xfer(895, 2000);
    @(posedge clk); #1;
    bus.rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_outclk", 32'(bus.outclk), 0);
      check("stall_done", 32'(bus.done), 0);
      check("stall_busy", 32'(bus.busy), 1);
    end
    @(posedge clk); #1;
    bus.rdy = 1'b1;
    @(negedge clk);
    check("done_after_stall", 32'(bus.done), 1);
    post_packet();

    // start during DATA is ignored; rst at data byte 300 aborts.
    send_start(8'h11);
    wait_xfer(200, 2000);
    @(posedge clk); #1;
    bus.offset = 8'h77;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    wait_xfer(428, 2000);
    @(posedge clk); #1;
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    sb_q.delete();
    addr_q.delete();
    #2 flush = 1'b0;
    rdy_rand = 1'b1;
    send_start(8'hFF);
    run_packet(20000, nc, nx);
    check("after_abort_xfers", 32'(nx), 896);
    rdy_rand = 1'b0;
    bus.rdy  = 1'b1;
    post_packet();

    // start held high: two packets with exactly one idle cycle between.
    @(posedge clk); #1;
    push_packet(8'h33);
    xfer_cnt   = 0;
    bus.offset = 8'h33;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    run_packet(2000, nc, nx);
    check("held1_cycles", 32'(nc), 896);
    check("held1_xfers", 32'(nx), 896);
    @(posedge clk); #1;
    push_packet(8'h44);
    xfer_cnt   = 0;
    bus.offset = 8'h44;
    @(negedge clk);
    check("gap_outclk", 32'(bus.outclk), 0);
    check("gap_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    run_packet(2000, nc, nx);
    check("held2_cycles", 32'(nc), 896);
    check("held2_xfers", 32'(nx), 896);
    post_packet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
